mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported, variable-latency unified memory between the pipelined MIPS instruction fetch (F stage) and data access (M stage). It serialises the two requesters through a req/ack memory handshake and raises a global stall until every pending access for the current cycle has completed. The pipeline then advances as one unit. The block sits between `mips` (fetch address `pc`, `memread`/`memwrite_M`, `aluout_M`, `writedata_M`) and the memory model.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- Fetch side:
- `if_req`  in  1  fetch requested at `if_addr`; held by the pipeline while `stall`=1.
- `if_addr`  in  AW  fetch address (`pc`).
- `if_rdata`  out  DW  fetched instruction (to `instr_F`); registered.
- Data side:
- `dm_read`  in  1  load in M stage.
- `dm_write`  in  1  store in M stage; `dm_read`=`dm_write`=1 is treated as a write.
- `dm_addr`  in  AW  data address (`aluout_M`).
- `dm_wdata`  in  DW  store data (`writedata_M`).
- `dm_rdata`  out  DW  load data (to `read_data_M`); registered.
- Control:
- `stall`  out  1  freeze the whole pipeline (combinational).
- Memory side:
- `mem_req`  out  1  transaction request; registered.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  AW  transaction address.
- `mem_wdata`  out  DW  write data.
- `mem_ack`  in  1  transaction complete this cycle; read data valid on `mem_rdata`.
- `mem_rdata`  in  DW  memory read data.
- Statistics:
- `stall_count`  out  32  saturating count of cycles with `stall`=1.

## Operation
- FSM states: IDLE, DATA, FETCH.
- Internal flags `dm_done` and `if_done` mark requests already served in the current pipeline cycle.
- `dm_pend` = `dm_read` | `dm_write`.
- `stall` = (`dm_pend` & !`dm_done`) | (`if_req` & !`if_done`).
- IDLE transitions:
  - If `dm_pend` & !`dm_done`: go to DATA. Data has fixed priority because the M-stage instruction is older.
  - Else if `if_req` & !`if_done`: go to FETCH.
  - On entry to either state, latch address, wdata and we into `mem_*` and set `mem_req`=1.
- DATA/FETCH: hold `mem_req` and all `mem_*` outputs stable until `mem_ack`=1. On the `mem_ack` edge:
  - Clear `mem_req` and return to IDLE.
  - DATA on a read: capture `mem_rdata` into `dm_rdata`. DATA on a write: leave `dm_rdata` unchanged. Set `dm_done`.
  - FETCH: capture `mem_rdata` into `if_rdata` and set `if_done`.
- A served flag is set only if its request is still asserted at `mem_ack`. If the request dropped mid-transaction, the transaction still completes, but the result is discarded and the output register is unchanged.
- When `stall`=0 at a rising edge, the pipeline advances: clear both done flags.
- `mem_ack` is ignored in IDLE.
- `stall_count` increments each cycle `stall`=1 and saturates at 0xFFFF_FFFF.

## Timing
- Reset values:
  - State = IDLE.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `if_rdata`=0, `dm_rdata`=0.
  - Both done flags = 0; `stall_count`=0.
  - `stall` follows its equation, so it reads 1 if a request is present during reset.
- Reset asserted mid-transaction: the transaction is abandoned immediately and `mem_req` drops asynchronously. The memory must tolerate a withdrawn request.
- Latency: 1 cycle IDLE → request, plus the memory wait. With `mem_ack` on the first `mem_req` cycle:
  - A single access stalls 2 cycles.
  - Data plus fetch in the same pipeline cycle stalls 4 cycles.
  - The first stall-free cycle is the cycle after the last `mem_ack`.
- Read data is visible on `if_rdata`/`dm_rdata` the cycle after `mem_ack` and is held until the next capture.
- No new transaction starts in the cycle `mem_ack` is high. Back-to-back transactions are separated by exactly one IDLE cycle.

## Test plan
- Reset then `if_req`=1, `if_addr`=0x0, memory acks on the 1st req cycle returning 0x20080005.
  - `mem_req` rises at cycle 1.
  - `stall`=1 for cycles 0–1.
  - `if_rdata`=0x20080005 and `stall`=0 at cycle 2.
  - `stall_count`=2.
- Fetch 0x4 plus `dm_read` at 0x40 in the same cycle, ack latency 3.
  - The data transaction is issued first with `mem_addr`=0x40.
  - The fetch follows after one IDLE cycle.
  - `stall` lasts 8 cycles.
  - `dm_rdata` and `if_rdata` hold the respective memory words.
- `dm_write`=1, `dm_addr`=0x54, `dm_wdata`=0xDEADBEEF.
  - `mem_we`=1, `mem_addr`=0x54 and `mem_wdata`=0xDEADBEEF stay stable until ack.
  - `dm_rdata` is unchanged.
- Assert `reset` while in FETCH with `mem_req`=1.
  - `mem_req`=0 immediately.
  - State IDLE and `stall_count`=0.
  - `if_rdata` is 0 afterwards.
- Drop `if_req` while in FETCH, then ack with 0x12345678.
  - `if_rdata` is unchanged and `if_done` stays 0.
  - Return to IDLE.
- Force `stall_count` to 0xFFFFFFFE and hold a request unacked for 5 cycles.
  - The count stops at 0xFFFFFFFF.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises MIPS fetch and data accesses onto a single
// req/ack memory port and stalls the pipeline until every access needed
// for the current pipeline cycle has been served.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_read,
  input  logic          dm_write,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [31:0]   stall_count
);

  typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

  state_t state, state_nxt;
  logic   dm_done, if_done;
  logic   dm_pend, dm_need, if_need;
  logic   start_dm, start_if, ack_dm, ack_if;

  assign dm_pend = dm_read | dm_write;
  assign dm_need = dm_pend & ~dm_done;
  assign if_need = if_req & ~if_done;
  assign stall   = dm_need | if_need;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: data wins because the M-stage instruction is older
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dm_need)      state_nxt = DATA;
        else if (if_need) state_nxt = FETCH;
      end
      DATA, FETCH: if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM decode into launch / completion strobes for the datapath
  always_comb begin
    start_dm = 1'b0;
    start_if = 1'b0;
    ack_dm   = 1'b0;
    ack_if   = 1'b0;
    case (state)
      IDLE: begin
        start_dm = dm_need;
        start_if = ~dm_need & if_need;
      end
      DATA:  ack_dm = mem_ack;
      FETCH: ack_if = mem_ack;
      default: ;
    endcase
  end

  // Memory request register: launched from IDLE, held stable until ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (start_dm) begin
      mem_req   <= 1'b1;
      mem_we    <= dm_write;
      mem_addr  <= dm_addr;
      mem_wdata <= dm_wdata;
    end else if (start_if) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= if_addr;
    end else if (ack_dm || ack_if) begin
      mem_req   <= 1'b0;
    end
  end

  // Read data capture; results of withdrawn requests are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if (ack_dm && dm_pend && !mem_we) dm_rdata <= mem_rdata;
      if (ack_if && if_req)             if_rdata <= mem_rdata;
    end
  end

  // Served flags: set on completion, cleared when the pipeline advances
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dm_done <= 1'b0;
      if_done <= 1'b0;
    end else if (!stall) begin
      dm_done <= 1'b0;
      if_done <= 1'b0;
    end else begin
      if (ack_dm && dm_pend) dm_done <= 1'b1;
      if (ack_if && if_req)  if_done <= 1'b1;
    end
  end

  // Saturating stall cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             stall_count <= '0;
    else if (stall && stall_count != '1)   stall_count <= stall_count + 32'd1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a req/ack memory responder with programmable
// latency plus directed scenarios and a randomized run checked against a
// transaction-level reference model.
module tb_mem_port_arbiter;

  logic        clk, reset;
  logic        if_req, dm_read, dm_write, stall, mem_req, mem_we, mem_ack;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, stall_count;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  int cyc = 0;

  logic [31:0] mem_dev [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          start_cyc_q[$];
  int          ack_cyc_q[$];
  logic [31:0] tr_addr_q[$];
  logic        tr_we_q[$];

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_count(stall_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Memory responder: acks on the lat-th cycle of each request and checks
  // that the request stays stable while it waits.
  initial begin
    int cnt;
    logic [31:0] a0, w0;
    logic we0;
    cnt = 0; a0 = 0; w0 = 0; we0 = 0;
    mem_ack = 0;
    mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (reset || !mem_req) begin
        cnt = 0;
        mem_ack = 0;
      end else begin
        if (cnt == 0) begin
          a0 = mem_addr; w0 = mem_wdata; we0 = mem_we;
          start_cyc_q.push_back(cyc);
        end else begin
          checks++;
          if (mem_addr !== a0 || mem_we !== we0 || (we0 && mem_wdata !== w0)) begin
            failures++;
            $display("FAIL mem_stable: got addr=%h we=%b wdata=%h, want addr=%h we=%b wdata=%h",
                     mem_addr, mem_we, mem_wdata, a0, we0, w0);
          end
        end
        cnt++;
        if (cnt == lat) begin
          mem_ack = 1;
          if (we0) begin
            mem_dev[a0] = w0;
            mem_rdata = 32'hBAD00000 ^ cyc;
          end else begin
            mem_rdata = mem_dev.exists(a0) ? mem_dev[a0] : init_word(a0);
          end
          ack_cyc_q.push_back(cyc);
          tr_addr_q.push_back(a0);
          tr_we_q.push_back(we0);
        end else begin
          mem_ack = 0;
        end
      end
    end
  end

  task automatic clear_log();
    start_cyc_q.delete(); ack_cyc_q.delete(); tr_addr_q.delete(); tr_we_q.delete();
  endtask

  task automatic test_reset();
    reset = 1;
    if_req = 0; if_addr = 0; dm_read = 0; dm_write = 0; dm_addr = 0; dm_wdata = 0;
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    checks++; if (if_rdata !== 32'h0) begin failures++; $display("FAIL rst_if_rdata: got %h want 0", if_rdata); end
    checks++; if (dm_rdata !== 32'h0) begin failures++; $display("FAIL rst_dm_rdata: got %h want 0", dm_rdata); end
    checks++; if (stall_count !== 32'h0) begin failures++; $display("FAIL rst_stall_count: got %h want 0", stall_count); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall_idle: got %b want 0", stall); end
    if_req = 1;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rst_stall_req: got %b want 1", stall); end
    if_req = 0;
  endtask

  task automatic test_single_fetch();
    lat = 1;
    mem_dev[32'h0] = 32'h20080005;
    @(negedge clk);
    reset = 0; if_req = 1; if_addr = 32'h0;
    #1;
    checks++; if (stall !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL fetch_c0: got stall=%b req=%b want 1/0", stall, mem_req); end
    @(negedge clk);
    checks++; if (stall !== 1'b1 || mem_req !== 1'b1) begin failures++; $display("FAIL fetch_c1: got stall=%b req=%b want 1/1", stall, mem_req); end
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL fetch_c2_stall: got %b want 0", stall); end
    checks++; if (if_rdata !== 32'h20080005) begin failures++; $display("FAIL fetch_rdata: got %h want 20080005", if_rdata); end
    checks++; if (stall_count !== 32'd2) begin failures++; $display("FAIL fetch_stall_count: got %0d want 2", stall_count); end
    @(negedge clk);
    if_req = 0;
  endtask

  task automatic test_data_fetch();
    int n;
    lat = 3;
    clear_log();
    @(negedge clk);
    if_req = 1; if_addr = 32'h4; dm_read = 1; dm_addr = 32'h40;
    #1;
    n = 0;
    while (stall && n < 50) begin n++; @(negedge clk); end
    checks++; if (n !== 8) begin failures++; $display("FAIL df_stall_len: got %0d want 8", n); end
    checks++;
    if (tr_addr_q.size() < 2 || start_cyc_q.size() < 2 || ack_cyc_q.size() < 1) begin
      failures++; $display("FAIL df_txn_count: got %0d want 2", tr_addr_q.size());
    end else begin
      if (tr_addr_q[0] !== 32'h40 || tr_we_q[0] !== 1'b0 || tr_addr_q[1] !== 32'h4) begin
        failures++; $display("FAIL df_order: got %h,%h want 00000040,00000004", tr_addr_q[0], tr_addr_q[1]);
      end
      checks++;
      if (start_cyc_q[1] - ack_cyc_q[0] !== 2) begin
        failures++; $display("FAIL df_gap: got %0d want 2", start_cyc_q[1] - ack_cyc_q[0]);
      end
    end
    checks++; if (dm_rdata !== init_word(32'h40)) begin failures++; $display("FAIL df_dm_rdata: got %h want %h", dm_rdata, init_word(32'h40)); end
    checks++; if (if_rdata !== init_word(32'h4)) begin failures++; $display("FAIL df_if_rdata: got %h want %h", if_rdata, init_word(32'h4)); end
    @(negedge clk);
    if_req = 0; dm_read = 0;
  endtask

  task automatic test_write();
    int n;
    logic [31:0] old;
    lat = 4;
    old = dm_rdata;
    @(negedge clk);
    dm_write = 1; dm_addr = 32'h54; dm_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h54 || mem_wdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL wr_issue: got req=%b we=%b addr=%h wdata=%h", mem_req, mem_we, mem_addr, mem_wdata);
    end
    n = 1;
    while (stall && n < 50) begin n++; @(negedge clk); end
    checks++; if (n !== 5) begin failures++; $display("FAIL wr_stall_len: got %0d want 5", n); end
    checks++; if (dm_rdata !== old) begin failures++; $display("FAIL wr_dm_rdata: got %h want %h", dm_rdata, old); end
    checks++;
    if (!mem_dev.exists(32'h54) || mem_dev[32'h54] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL wr_mem: memory at 54 not written with deadbeef");
    end
    @(negedge clk);
    dm_write = 0;
  endtask

  task automatic test_drop();
    int n;
    logic [31:0] old;
    lat = 3;
    mem_dev[32'h8] = 32'h12345678;
    old = if_rdata;
    @(negedge clk);
    if_req = 1; if_addr = 32'h8;
    n = 0;
    while (!mem_req && n < 20) begin n++; @(negedge clk); end
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL drop_req: got %b want 1", mem_req); end
    @(negedge clk);
    if_req = 0;
    repeat (3) @(negedge clk);
    checks++; if (if_rdata !== old) begin failures++; $display("FAIL drop_if_rdata: got %h want %h", if_rdata, old); end
    checks++; if (dut.if_done !== 1'b0) begin failures++; $display("FAIL drop_if_done: got %b want 0", dut.if_done); end
    checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL drop_idle: got req=%b stall=%b want 0/0", mem_req, stall); end
  endtask

  task automatic test_reset_mid();
    int n;
    lat = 20;
    @(negedge clk);
    if_req = 1; if_addr = 32'hC;
    n = 0;
    while (!mem_req && n < 20) begin n++; @(negedge clk); end
    @(negedge clk);
    #2 reset = 1;
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rstmid_req: got %b want 0", mem_req); end
    checks++; if (stall_count !== 32'h0) begin failures++; $display("FAIL rstmid_count: got %h want 0", stall_count); end
    checks++; if (if_rdata !== 32'h0) begin failures++; $display("FAIL rstmid_if_rdata: got %h want 0", if_rdata); end
    if_req = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rstmid_idle: got req=%b stall=%b want 0/0", mem_req, stall); end
  endtask

  task automatic test_saturate();
    lat = 1000;
    @(negedge clk);
    if_req = 1; if_addr = 32'h10;
    @(negedge clk);
    force dut.stall_count = 32'hFFFFFFFE;
    #1 release dut.stall_count;
    @(negedge clk);
    checks++; if (stall_count !== 32'hFFFFFFFF) begin failures++; $display("FAIL sat_step: got %h want ffffffff", stall_count); end
    repeat (5) @(negedge clk);
    checks++; if (stall_count !== 32'hFFFFFFFF) begin failures++; $display("FAIL sat_hold: got %h want ffffffff", stall_count); end
    reset = 1; if_req = 0;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_random();
    int n, want_n, nacc;
    logic [31:0] exp_dm, exp_if, exp_cnt, a_dm, a_if, wd;
    logic rd, wr, fr;
    exp_dm = 0; exp_if = 0; exp_cnt = 0;
    for (int it = 0; it < 40; it++) begin
      rd = $urandom_range(0, 1); wr = ($urandom_range(0, 3) == 0); fr = $urandom_range(0, 1);
      a_dm = 32'h100 + 4 * $urandom_range(0, 7);
      a_if = 32'h100 + 4 * $urandom_range(0, 7);
      wd = $urandom;
      lat = $urandom_range(1, 4);
      // Reference: data access is performed before the fetch
      if (wr) ref_mem[a_dm] = wd;
      else if (rd) exp_dm = ref_mem.exists(a_dm) ? ref_mem[a_dm] : init_word(a_dm);
      if (fr) exp_if = ref_mem.exists(a_if) ? ref_mem[a_if] : init_word(a_if);
      nacc = ((rd || wr) ? 1 : 0) + (fr ? 1 : 0);
      want_n = nacc * (lat + 1);
      exp_cnt += want_n;
      @(negedge clk);
      dm_read = rd; dm_write = wr; dm_addr = a_dm; dm_wdata = wd; if_req = fr; if_addr = a_if;
      #1;
      n = 0;
      while (stall && n < 100) begin n++; @(negedge clk); end
      checks++; if (n !== want_n) begin failures++; $display("FAIL rnd_stall_len it=%0d: got %0d want %0d", it, n, want_n); end
      checks++; if (dm_rdata !== exp_dm) begin failures++; $display("FAIL rnd_dm_rdata it=%0d: got %h want %h", it, dm_rdata, exp_dm); end
      checks++; if (if_rdata !== exp_if) begin failures++; $display("FAIL rnd_if_rdata it=%0d: got %h want %h", it, if_rdata, exp_if); end
      checks++; if (stall_count !== exp_cnt) begin failures++; $display("FAIL rnd_stall_count it=%0d: got %0d want %0d", it, stall_count, exp_cnt); end
      @(negedge clk);
      dm_read = 0; dm_write = 0; if_req = 0;
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_data_fetch();
    test_write();
    test_drop();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
